// File: rtl/ms_timer_bank.sv
// Four delay timers sharing one tick divider; loads are granted round-robin,
// one per cycle, and each armed channel counts down on ticks to a done pulse.
module ms_timer_bank #(
  parameter int unsigned CLK_HZ  = 50000000,
  parameter int unsigned TICK_HZ = 1000,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                 clk_in,
  input  logic                 rst_n,
  input  logic [3:0]           req,
  input  logic [4*CNT_W-1:0]   req_ms,
  input  logic [3:0]           cancel,
  output logic [3:0]           grant,
  output logic [3:0]           busy,
  output logic [3:0]           done,
  output logic                 tick
);

  localparam int unsigned DIV   = CLK_HZ / TICK_HZ;
  localparam int unsigned DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ARMED = 1'b1
  } ch_state_e;

  // ---------------- tick divider ----------------
  logic [DIV_W-1:0] div_q, div_d;

  always_comb begin
    div_d = div_q + DIV_W'(1);
    if (div_q == DIV_LAST) begin
      div_d = '0;
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      div_q <= '0;
    end else begin
      div_q <= div_d;
    end
  end

  assign tick = (div_q == DIV_LAST);

  // ---------------- round-robin load arbiter ----------------
  logic [1:0] ptr_q, ptr_d;
  logic [3:0] grant_q, grant_d;
  logic [3:0] eligible;
  logic [1:0] arb_idx;
  logic       arb_found;

  assign eligible = req & ~busy;

  // Search starts one past the last winner so every requester gets a turn.
  always_comb begin
    grant_d   = '0;
    ptr_d     = ptr_q;
    arb_found = 1'b0;
    arb_idx   = ptr_q;
    for (int k = 1; k <= 4; k++) begin
      arb_idx = ptr_q + 2'(k);
      if (!arb_found && eligible[arb_idx]) begin
        arb_found        = 1'b1;
        grant_d[arb_idx] = 1'b1;
        ptr_d            = arb_idx;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      ptr_q   <= 2'd3;
      grant_q <= '0;
    end else begin
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
    end
  end

  assign grant = grant_q;

  // ---------------- per-channel countdown ----------------
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_ch
      ch_state_e        state_q, state_d;
      logic [CNT_W-1:0] rem_q, rem_d;
      logic [CNT_W-1:0] ld_ms;
      logic [CNT_W-1:0] load_val;
      logic             done_q, done_d;

      assign ld_ms    = req_ms[gi*CNT_W +: CNT_W];
      assign load_val = (ld_ms == '0) ? CNT_W'(1) : ld_ms;

      // Cancel is checked before the tick so it wins over a same-cycle expiry.
      always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        done_d  = 1'b0;
        case (state_q)
          ST_IDLE: begin
            if (grant_d[gi]) begin
              state_d = ST_ARMED;
              rem_d   = load_val;
            end
          end
          ST_ARMED: begin
            if (cancel[gi]) begin
              state_d = ST_IDLE;
              rem_d   = '0;
            end else if (tick) begin
              if (rem_q <= CNT_W'(1)) begin
                state_d = ST_IDLE;
                rem_d   = '0;
                done_d  = 1'b1;
              end else begin
                rem_d = rem_q - CNT_W'(1);
              end
            end
          end
          default: begin
            state_d = ST_IDLE;
            rem_d   = '0;
          end
        endcase
      end

      always_ff @(posedge clk_in) begin
        if (!rst_n) begin
          state_q <= ST_IDLE;
          rem_q   <= '0;
          done_q  <= 1'b0;
        end else begin
          state_q <= state_d;
          rem_q   <= rem_d;
          done_q  <= done_d;
        end
      end

      assign busy[gi] = (state_q == ST_ARMED);
      assign done[gi] = done_q;
    end
  endgenerate

endmodule

// File: tb/tb_ms_timer_bank.sv
// Directed bench for ms_timer_bank (DIV=10, CNT_W=8); expected grant/done events
// are queued with their cycle numbers and matched by a per-cycle monitor.
module tb_ms_timer_bank;

  localparam int CNT_W = 8;

  logic               clk;
  logic               rst_n;
  logic [3:0]         req;
  logic [4*CNT_W-1:0] req_ms;
  logic [3:0]         cancel;
  logic [3:0]         grant;
  logic [3:0]         busy;
  logic [3:0]         done;
  logic               tick;

  int  errors = 0;
  int  checks = 0;
  int  cyc    = 0;
  bit  chk_en = 0;

  typedef struct {
    int         cyc;
    logic [3:0] g;
    logic [3:0] d;
  } sb_t;
  sb_t sbq[$];

  ms_timer_bank #(
    .CLK_HZ (20),
    .TICK_HZ(2),
    .CNT_W  (CNT_W)
  ) dut (
    .clk_in(clk),
    .rst_n (rst_n),
    .req   (req),
    .req_ms(req_ms),
    .cancel(cancel),
    .grant (grant),
    .busy  (busy),
    .done  (done),
    .tick  (tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // cyc == 1 in the first cycle after the last reset edge (divider count 0).
  always @(posedge clk) begin
    if (!rst_n) cyc <= 1;
    else        cyc <= cyc + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  function automatic int next_tick(input int c);
    return ((c + 9) / 10) * 10;
  endfunction

  // Done lands the cycle after the N-th tick seen while armed (first armed cycle counts).
  function automatic int done_cyc(input int g, input int n);
    int nn;
    nn = (n == 0) ? 1 : n;
    return next_tick(g) + (nn - 1) * 10 + 1;
  endfunction

  task automatic push(input int c, input logic [3:0] g, input logic [3:0] d);
    sbq.push_back('{c, g, d});
  endtask

  task automatic set_ms(input int ch, input int val);
    req_ms[ch*CNT_W +: CNT_W] = CNT_W'(val);
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  // Per-cycle monitor: pops whatever the scoreboard expects for this cycle.
  always @(negedge clk) begin
    logic [3:0] eg;
    logic [3:0] ed;
    if (chk_en) begin
      eg = '0;
      ed = '0;
      for (int i = sbq.size() - 1; i >= 0; i--) begin
        if (sbq[i].cyc == cyc) begin
          eg = eg | sbq[i].g;
          ed = ed | sbq[i].d;
          sbq.delete(i);
        end
      end
      chk("grant", 32'(grant), 32'(eg));
      chk("done", 32'(done), 32'(ed));
      chk("tick", 32'(tick), 32'((cyc % 10) == 0));
      $display("cyc=%0d tick=%b req=%b grant=%b busy=%b done=%b", cyc, tick, req, grant, busy, done);
    end
  end

  initial begin
    rst_n  = 1'b0;
    req    = '0;
    req_ms = '0;
    cancel = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", 32'({grant, busy, done, tick}), 32'd0);
    rst_n  = 1'b1;
    chk_en = 1'b1;

    // Idle: ticks at 10,20,30 checked by the monitor. Then all four request 5 ticks.
    wait_cyc(31);
    req = 4'b1111;
    for (int ch = 0; ch < 4; ch++) set_ms(ch, 5);
    push(32, 4'b0001, 4'b0000);
    push(33, 4'b0010, 4'b0000);
    push(34, 4'b0100, 4'b0000);
    push(35, 4'b1000, 4'b0000);
    push(81, 4'b0000, 4'b1111);
    push(82, 4'b0001, 4'b0000);
    push(83, 4'b0010, 4'b0000);
    push(84, 4'b0100, 4'b0000);
    push(85, 4'b1000, 4'b0000);
    push(131, 4'b0000, 4'b1111);
    wait_cyc(35);
    chk("busy_all_round1", 32'(busy), 32'hF);
    wait_cyc(81);
    chk("busy_clear_at_done", 32'(busy), 32'h0);
    wait_cyc(85);
    chk("busy_all_round2", 32'(busy), 32'hF);
    req = 4'b0000;
    wait_cyc(131);
    chk("busy_clear_round2", 32'(busy), 32'h0);

    // Single channel 0, delay 3.
    wait_cyc(140);
    req = 4'b0001;
    set_ms(0, 3);
    push(141, 4'b0001, 4'b0000);
    push(done_cyc(141, 3), 4'b0000, 4'b0001);
    wait_cyc(141);
    req = 4'b0000;
    chk("busy0_after_grant", 32'(busy[0]), 32'd1);
    wait_cyc(done_cyc(141, 3) - 1);
    chk("busy0_before_done", 32'(busy[0]), 32'd1);
    wait_cyc(done_cyc(141, 3));
    chk("busy0_at_done", 32'(busy[0]), 32'd0);

    // Zero delay on channel 2 behaves as one tick.
    wait_cyc(175);
    req = 4'b0100;
    set_ms(2, 0);
    push(176, 4'b0100, 4'b0000);
    push(done_cyc(176, 0), 4'b0000, 4'b0100);
    wait_cyc(176);
    req = 4'b0000;
    wait_cyc(done_cyc(176, 0));
    chk("busy2_zero_delay", 32'(busy[2]), 32'd0);

    // Cancel channel 1 after two ticks: no done afterwards.
    wait_cyc(185);
    req = 4'b0010;
    set_ms(1, 4);
    push(186, 4'b0010, 4'b0000);
    wait_cyc(186);
    req = 4'b0000;
    wait_cyc(205);
    chk("busy1_before_cancel", 32'(busy[1]), 32'd1);
    cancel = 4'b0010;
    wait_cyc(206);
    cancel = 4'b0000;
    chk("busy1_after_cancel", 32'(busy[1]), 32'd0);

    // Cancel coinciding with the final tick suppresses done.
    wait_cyc(210);
    req = 4'b0010;
    set_ms(1, 2);
    push(211, 4'b0010, 4'b0000);
    wait_cyc(211);
    req = 4'b0000;
    wait_cyc(230);
    chk("busy1_at_final_tick", 32'(busy[1]), 32'd1);
    cancel = 4'b0010;
    wait_cyc(231);
    cancel = 4'b0000;
    chk("busy1_cancel_final", 32'(busy[1]), 32'd0);

    // Cancel on an idle channel being granted is ignored.
    wait_cyc(240);
    req    = 4'b1000;
    cancel = 4'b1000;
    set_ms(3, 1);
    push(241, 4'b1000, 4'b0000);
    push(done_cyc(241, 1), 4'b0000, 4'b1000);
    wait_cyc(241);
    req    = 4'b0000;
    cancel = 4'b0000;
    chk("busy3_grant_with_cancel", 32'(busy[3]), 32'd1);
    wait_cyc(done_cyc(241, 1));
    chk("busy3_after_done", 32'(busy[3]), 32'd0);

    // Reset mid-count on channel 0: everything drops, no done.
    wait_cyc(260);
    req = 4'b0001;
    set_ms(0, 6);
    push(261, 4'b0001, 4'b0000);
    wait_cyc(261);
    req = 4'b0000;
    wait_cyc(292);
    chk("busy0_before_reset", 32'(busy[0]), 32'd1);
    chk_en = 1'b0;
    rst_n  = 1'b0;
    @(negedge clk);
    chk("midreset_outputs", 32'({grant, busy, done, tick}), 32'd0);
    chk("sb_empty_at_reset", 32'(sbq.size()), 32'd0);
    rst_n  = 1'b1;
    chk_en = 1'b1;

    // After reset channel 0 has first priority again.
    wait_cyc(3);
    req = 4'b1111;
    for (int ch = 0; ch < 4; ch++) set_ms(ch, 1);
    push(4, 4'b0001, 4'b0000);
    push(5, 4'b0010, 4'b0000);
    push(6, 4'b0100, 4'b0000);
    push(7, 4'b1000, 4'b0000);
    push(11, 4'b0000, 4'b1111);
    wait_cyc(7);
    req = 4'b0000;
    wait_cyc(25);
    chk("sb_empty_at_end", 32'(sbq.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
